// File: rtl/sd_clk_ctrl.sv
// SD card clock divider and start/stop sequencer with glitch-free divider reload.
// Optional build macro SD_CLK_AUTOSTOP_EN: idle auto-stop driven by CMD/DAT clock requests.
module sd_clk_ctrl #(
  parameter int DIV_W         = 8,
  parameter int INIT_DIV      = 124,
  parameter int IDLE_STOP_CYC = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK_EN_I,
  input  logic             DIV_WR_I,
  input  logic [DIV_W-1:0] DIV_I,
  output logic             DIV_BUSY_O,
  output logic             DIV_ACK_O,
  input  logic             CMD_REQ_I,
  input  logic             DAT_REQ_I,
  output logic [DIV_W-1:0] CUR_DIV_O,
  output logic             CLK_RUN_O,
  output logic             SD_CLK_O,
  output logic             SD_RISE_O,
  output logic             SD_FALL_O
);

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  localparam int IDLE_W = (IDLE_STOP_CYC < 1) ? 1 : $clog2(IDLE_STOP_CYC + 1);
  localparam logic [IDLE_W:0]    IDLE_LIM   = (IDLE_W + 1)'(IDLE_STOP_CYC);
  localparam logic [DIV_W-1:0]   INIT_DIV_V = DIV_W'(INIT_DIV);

  logic [0:0]       state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_div;

  logic tick;
  logic fall_tick;
  logic run_demand;
  logic idle_hit;
  logic stop_req;
  logic apply_div;

  // A toggle happens when the half-period counter reaches the active divider.
  assign tick      = (state == ST_RUN) && (cnt == CUR_DIV_O);
  assign fall_tick = tick && SD_CLK_O;
  assign stop_req  = !CLK_EN_I || idle_hit;

  // A write in the same cycle wins over applying, so it waits for the next boundary.
  assign apply_div = DIV_BUSY_O && !DIV_WR_I && ((state == ST_STOPPED) || fall_tick);

  assign CLK_RUN_O = (state == ST_RUN);

`ifdef SD_CLK_AUTOSTOP_EN
  logic [IDLE_W-1:0] idle_cnt;
  logic              req_any;

  assign req_any    = CMD_REQ_I | DAT_REQ_I;
  assign run_demand = req_any;
  assign idle_hit   = fall_tick && !req_any &&
                      (({1'b0, idle_cnt} + (IDLE_W + 1)'(1)) >= IDLE_LIM);

  // Counts idle falling edges; any request or leaving RUN clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idle_cnt <= '0;
    end else if ((state != ST_RUN) || req_any || idle_hit) begin
      idle_cnt <= '0;
    end else if (fall_tick) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  logic unused_req;

  assign unused_req = CMD_REQ_I ^ DAT_REQ_I ^ (IDLE_LIM == '0);
  assign run_demand = 1'b1;
  assign idle_hit   = 1'b0;
`endif

  // State, half-period counter and SD clock with its edge strobes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_STOPPED;
      cnt       <= '0;
      SD_CLK_O  <= 1'b0;
      SD_RISE_O <= 1'b0;
      SD_FALL_O <= 1'b0;
    end else begin
      SD_RISE_O <= 1'b0;
      SD_FALL_O <= 1'b0;
      case (state)
        ST_STOPPED: begin
          SD_CLK_O <= 1'b0;
          cnt      <= '0;
          if (CLK_EN_I && run_demand) begin
            state <= ST_RUN;
          end
        end
        default: begin
          if (tick) begin
            cnt       <= '0;
            SD_CLK_O  <= ~SD_CLK_O;
            SD_RISE_O <= ~SD_CLK_O;
            SD_FALL_O <= SD_CLK_O;
            // Stopping only at a fall keeps SD_CLK low and every half-period whole.
            if (fall_tick && stop_req) begin
              state <= ST_STOPPED;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

  // Pending divider register and its handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_div   <= '0;
      DIV_BUSY_O <= 1'b0;
      DIV_ACK_O  <= 1'b0;
      CUR_DIV_O  <= INIT_DIV_V;
    end else begin
      DIV_ACK_O <= 1'b0;
      if (DIV_WR_I) begin
        pend_div   <= DIV_I;
        DIV_BUSY_O <= 1'b1;
      end else if (apply_div) begin
        CUR_DIV_O  <= pend_div;
        DIV_BUSY_O <= 1'b0;
        DIV_ACK_O  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sd_clk_ctrl.md
Name: sd_clk_ctrl

Overview:
Controller and sequencer for the SD card clock divider. Generates SD_CLK from CLK with a programmable half-period. Changes the divider without glitches: new values load only at a falling SD_CLK boundary. Starts and stops SD_CLK on software enable, plus requests from the command and data engines. Sits between the host register file and the SD command/data FSMs, and provides the rise and fall strobes those FSMs sample on.

Parameters:
DIV_W, 8, width of divider value
INIT_DIV, 124, divider loaded at reset (400 kHz from 100 MHz CLK)
IDLE_STOP_CYC, 8, number of idle SD_CLK periods before auto-stop (only with the optional feature)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
CLK_EN_I  in  1  software clock enable (level)
DIV_WR_I  in  1  one-cycle strobe: request new divider
DIV_I  in  DIV_W  new divider value, sampled when DIV_WR_I=1
DIV_BUSY_O  out  1  divider change pending
DIV_ACK_O  out  1  one-cycle pulse when the pending divider is applied
CMD_REQ_I  in  1  command path needs clock (level)
DAT_REQ_I  in  1  data path needs clock (level)
CUR_DIV_O  out  DIV_W  divider currently in use
CLK_RUN_O  out  1  high in RUN state
SD_CLK_O  out  1  registered SD clock
SD_RISE_O  out  1  one-cycle pulse in the cycle SD_CLK_O goes 0->1
SD_FALL_O  out  1  one-cycle pulse in the cycle SD_CLK_O goes 1->0

Behaviour:
- Reset values: state=STOPPED, SD_CLK_O=0, cnt=0, CUR_DIV_O=INIT_DIV, all strobes and flags 0, no divider pending, idle counter 0.
- Clock equation: SD_CLK half-period is CUR_DIV+1 CLK cycles, so the period is 2*(CUR_DIV+1). DIV=0 gives CLK/2.
- Counter in RUN: if cnt==CUR_DIV, then cnt<=0 and SD_CLK_O toggles. Otherwise cnt<=cnt+1.
- Edge strobes: SD_RISE_O / SD_FALL_O are registered alongside the toggle, so they are high in the same cycle the new SD_CLK_O level appears.
- State STOPPED:
  - SD_CLK_O is held 0 and cnt is held 0.
  - Enters RUN when CLK_EN_I=1 and run-demand=1.
  - Without the feature, run-demand=1. With the feature, run-demand=CMD_REQ_I|DAT_REQ_I.
  - A pending divider is applied in the cycle after it is seen in STOPPED, and DIV_ACK_O pulses.
  - If a divider is applied and RUN is entered in the same cycle, RUN uses the new value.
- State RUN:
  - The first rising edge occurs CUR_DIV+1 cycles after entry.
  - Stop condition: CLK_EN_I=0 or auto-stop. It is acted on only at a falling toggle. That fall completes, then the next state is STOPPED. SD_CLK_O is never left high, and a half-period is never shortened.
- Divider change:
  - DIV_WR_I latches DIV_I into a pending register and sets DIV_BUSY_O.
  - A second write while pending overwrites the value. Only one DIV_ACK_O is produced.
  - In RUN, the pending value loads into CUR_DIV at the next falling toggle, with cnt=0. DIV_ACK_O pulses in that same cycle and DIV_BUSY_O clears.
  - A write arriving in the same cycle as a falling toggle is held for the next falling toggle (or applied in STOPPED).
- Stop and divider load at the same falling edge: both take effect, DIV_ACK_O pulses, and the next state is STOPPED.
- CLK_EN_I dropping then rising again before the falling toggle: no stop occurs (the condition is level-evaluated at the toggle).
- RST mid-operation: immediate return to reset values. The pending divider is discarded and CUR_DIV_O returns to INIT_DIV.

Optional Feature:
SD_CLK_AUTOSTOP_EN
- Defined:
  - In RUN, an idle counter increments at each falling toggle while CMD_REQ_I=0 and DAT_REQ_I=0.
  - The counter clears whenever either request is high.
  - When it reaches IDLE_STOP_CYC at a falling toggle, the block stops, exactly as for CLK_EN_I=0.
  - In STOPPED, an asserted request (with CLK_EN_I=1) restarts the clock.
- Undefined: CMD_REQ_I and DAT_REQ_I are ignored, and the clock runs whenever CLK_EN_I=1.

Test Plan:
1. Reset, CLK_EN_I=1, DIV default 124 -> first SD_RISE_O 125 cycles after RUN entry, and SD_CLK_O period 250 CLK cycles.
2. Running at DIV=3, write DIV_I=0 mid-high-phase -> DIV_BUSY_O=1; at the next fall DIV_ACK_O pulses and CUR_DIV_O=0; from then on SD_CLK_O toggles every cycle; no half-period shorter than 4 cycles before the switch.
3. Two writes (5 then 9) before the falling edge -> a single DIV_ACK_O and CUR_DIV_O=9.
4. CLK_EN_I=0 while SD_CLK_O=1 at DIV=4 -> high phase completes its 5 cycles, SD_FALL_O pulses, then state is STOPPED with SD_CLK_O=0 and CLK_RUN_O=0.
5. SD_CLK_AUTOSTOP_EN, IDLE_STOP_CYC=8, requests low -> stops at the 8th idle fall; asserting CMD_REQ_I -> RUN next cycle and SD_RISE_O after CUR_DIV+1 cycles.
6. Assert RST mid-high-phase with a divider pending -> SD_CLK_O=0 immediately, CUR_DIV_O=124, DIV_BUSY_O=0, and no DIV_ACK_O.
